// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared rv32i types for the pipeline: opcode encodings plus the hazard
// controller's state enum and the NOP destination register.
package rv32i_types;

  typedef enum logic [6:0] {
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111,
    OP_JAL   = 7'b1101111,
    OP_JALR  = 7'b1100111,
    OP_BR    = 7'b1100011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_IMM   = 7'b0010011,
    OP_REG   = 7'b0110011,
    OP_CSR   = 7'b1110011
  } rv32i_opcode_t;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_FLUSH   = 2'd1,
    S_LDSTALL = 2'd2
  } hazard_state_t;

  localparam logic [4:0] NOP_RD = 5'd0;

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter used for the hazard unit's performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard and redirect controller beside decode: EX mispredict redirects,
// ID/EX load-use stalls, and multi-cycle bubble/stall sequencing.
module hazard_ctrl_unit
  import rv32i_types::*;
#(
  parameter int XLEN            = 32,
  parameter int LOAD_USE_STALLS = 1,
  parameter int FLUSH_BUBBLES   = 1,
  parameter int CNT_W           = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_ready,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            ex_valid,
  input  logic [6:0]      ex_opcode,
  input  logic [4:0]      ex_rd,
  input  logic            ex_br_en,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  output logic            stall_fetch,
  output logic            id_bubble,
  output logic            flush_if,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy,
  output logic [CNT_W-1:0] mispredict_cnt,
  output logic [CNT_W-1:0] loaduse_cnt
);

  localparam int MAX_CYC = (LOAD_USE_STALLS > FLUSH_BUBBLES) ? LOAD_USE_STALLS : FLUSH_BUBBLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_BUBBLES);
  localparam logic [CW-1:0] STALL_LOAD = CW'(LOAD_USE_STALLS - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  hazard_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic op_br, op_jal, op_jalr, op_load;
  logic taken, nt, mispred, loaduse;
  logic [XLEN-1:0] pc_plus4;
  logic inc_mis, inc_lu;

  assign op_br   = (ex_opcode == OP_BR);
  assign op_jal  = (ex_opcode == OP_JAL);
  assign op_jalr = (ex_opcode == OP_JALR);
  assign op_load = (ex_opcode == OP_LOAD);

  assign pc_plus4 = ex_pc + XLEN'(4);
  assign taken    = ex_valid & ((op_br & ex_br_en) | op_jal | op_jalr);
  assign nt       = ex_valid & op_br & ~ex_br_en;
  assign mispred  = id_valid & ((taken & (id_pc != ex_target)) | (nt & (id_pc != pc_plus4)));
  assign loaduse  = ex_valid & op_load & (ex_rd != NOP_RD) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the branches leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    stall_fetch    = 1'b0;
    id_bubble      = 1'b0;
    flush_if       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    busy           = 1'b0;
    inc_mis        = 1'b0;
    inc_lu         = 1'b0;

    if (!rst_n) begin
      // outputs stay at their zero defaults while reset is asserted
    end else if (!mem_ready) begin
      // cache miss: only hold fetch; FSM and counters freeze
      stall_fetch = 1'b1;
    end else begin
      busy        = (state_q != S_RUN);
      redirect_pc = taken ? ex_target : pc_plus4;

      if (mispred) begin
        redirect_valid = 1'b1;
        flush_if       = 1'b1;
        id_bubble      = 1'b1;
        inc_mis        = 1'b1;
        if (FLUSH_BUBBLES > 0) begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_LOAD;
        end else begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end else if (loaduse && (state_q != S_LDSTALL)) begin
        stall_fetch = 1'b1;
        id_bubble   = 1'b1;
        inc_lu      = 1'b1;
        if (LOAD_USE_STALLS > 1) begin
          state_d = S_LDSTALL;
          cnt_d   = STALL_LOAD;
        end else begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end else begin
        unique case (state_q)
          S_FLUSH: begin
            id_bubble = 1'b1;
            if (cnt_q == CNT_ONE) begin
              state_d = S_RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          S_LDSTALL: begin
            stall_fetch = 1'b1;
            id_bubble   = 1'b1;
            if (cnt_q == CNT_ONE) begin
              state_d = S_RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          default: begin
            state_d = S_RUN;
          end
        endcase
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_mispredict_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_mis),
    .q     (mispredict_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_loaduse_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_lu),
    .q     (loaduse_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: a reference model driven by a queue of
// scheduled future actions predicts every cycle; a monitor compares at negedge.
module tb_hazard_ctrl_unit;
  import rv32i_types::*;

  localparam int XLEN    = 32;
  localparam int LUS     = 2;
  localparam int FB      = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mem_ready = 1'b0;
  logic            id_valid = 1'b0;
  logic [XLEN-1:0] id_pc = '0;
  logic [4:0]      id_rs1 = '0, id_rs2 = '0;
  logic            id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic            ex_valid = 1'b0;
  logic [6:0]      ex_opcode = '0;
  logic [4:0]      ex_rd = '0;
  logic            ex_br_en = 1'b0;
  logic [XLEN-1:0] ex_pc = '0, ex_target = '0;
  logic            stall_fetch, id_bubble, flush_if, redirect_valid, busy;
  logic [XLEN-1:0] redirect_pc;
  logic [CNT_W-1:0] mispredict_cnt, loaduse_cnt;

  hazard_ctrl_unit #(
    .XLEN(XLEN), .LOAD_USE_STALLS(LUS), .FLUSH_BUBBLES(FB), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mem_ready(mem_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_br_en(ex_br_en),
    .ex_pc(ex_pc), .ex_target(ex_target),
    .stall_fetch(stall_fetch), .id_bubble(id_bubble), .flush_if(flush_if),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy),
    .mispredict_cnt(mispredict_cnt), .loaduse_cnt(loaduse_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            mem_ready, id_valid, use1, use2, ex_valid, br_en;
    logic [XLEN-1:0] id_pc, ex_pc, target;
    logic [4:0]      rs1, rs2, rd;
    logic [6:0]      op;
  } stim_t;

  typedef struct {
    logic            stall, bubble, flush, rv, busy;
    logic [XLEN-1:0] rpc;
    int              mcnt, lcnt;
  } exp_t;

  typedef enum {A_BUBBLE, A_STALL} action_t;

  exp_t    exp_q[$];
  action_t pend[$];   // actions the pipeline still owes in future ready cycles
  int      mis_n, lu_n;
  int      n_checks, n_errors;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Reference model: pipeline rules applied directly to the architectural inputs.
  task automatic model(input stim_t s, input bit rst_low);
    exp_t e;
    logic [XLEN-1:0] pc4;
    logic is_taken, is_nt, mis, lu;
    e = '{default: '0};
    if (rst_low) begin
      pend.delete();
      mis_n = 0;
      lu_n  = 0;
    end else if (!s.mem_ready) begin
      e.stall = 1'b1;
      e.mcnt  = (mis_n > CNT_MAX) ? CNT_MAX : mis_n;
      e.lcnt  = (lu_n > CNT_MAX) ? CNT_MAX : lu_n;
    end else begin
      e.mcnt   = (mis_n > CNT_MAX) ? CNT_MAX : mis_n;
      e.lcnt   = (lu_n > CNT_MAX) ? CNT_MAX : lu_n;
      e.busy   = (pend.size() > 0);
      pc4      = s.ex_pc + 32'd4;
      is_taken = s.ex_valid && ((s.op == OP_BR && s.br_en) || s.op == OP_JAL || s.op == OP_JALR);
      is_nt    = s.ex_valid && s.op == OP_BR && !s.br_en;
      mis      = s.id_valid && ((is_taken && s.id_pc != s.target) || (is_nt && s.id_pc != pc4));
      lu       = s.ex_valid && s.op == OP_LOAD && s.rd != 0 &&
                 ((s.use1 && s.rs1 == s.rd) || (s.use2 && s.rs2 == s.rd));
      e.rpc    = is_taken ? s.target : pc4;
      if (mis) begin
        e.rv = 1; e.flush = 1; e.bubble = 1;
        mis_n++;
        pend.delete();
        repeat (FB) pend.push_back(A_BUBBLE);
      end else if (lu && !(pend.size() > 0 && pend[0] == A_STALL)) begin
        e.stall = 1; e.bubble = 1;
        lu_n++;
        pend.delete();
        repeat (LUS - 1) pend.push_back(A_STALL);
      end else if (pend.size() > 0) begin
        action_t a;
        a = pend.pop_front();
        e.bubble = 1;
        e.stall  = (a == A_STALL);
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input stim_t s, input bit rst_low);
    @(posedge clk);
    #1;
    rst_n      = !rst_low;
    mem_ready  = s.mem_ready;
    id_valid   = s.id_valid;   id_pc     = s.id_pc;
    id_rs1     = s.rs1;        id_rs2    = s.rs2;
    id_use_rs1 = s.use1;       id_use_rs2 = s.use2;
    ex_valid   = s.ex_valid;   ex_opcode = s.op;
    ex_rd      = s.rd;         ex_br_en  = s.br_en;
    ex_pc      = s.ex_pc;      ex_target = s.target;
    model(s, rst_low);
    #2;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.mem_ready = 1'b1;
    return s;
  endfunction

  function automatic stim_t jal_at(input logic [XLEN-1:0] target, input logic [XLEN-1:0] idpc);
    stim_t s;
    s = idle();
    s.ex_valid = 1; s.op = OP_JAL; s.target = target; s.id_valid = 1; s.id_pc = idpc;
    return s;
  endfunction

  function automatic stim_t lw_at(input logic [4:0] rd, input logic [4:0] r1, input logic u1);
    stim_t s;
    s = idle();
    s.ex_valid = 1; s.op = OP_LOAD; s.rd = rd; s.id_valid = 1;
    s.rs1 = r1; s.use1 = u1; s.rs2 = 5'd1; s.use2 = u1;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    logic [6:0] ops [7];
    ops = '{OP_BR, OP_JAL, OP_JALR, OP_LOAD, OP_REG, OP_IMM, OP_LUI};
    s.mem_ready = ($urandom_range(0, 99) < 85);
    s.id_valid  = ($urandom_range(0, 99) < 85);
    s.ex_valid  = ($urandom_range(0, 99) < 80);
    s.op        = ops[$urandom_range(0, 6)];
    s.br_en     = $urandom_range(0, 1);
    s.rd        = 5'($urandom_range(0, 3));
    s.rs1       = 5'($urandom_range(0, 3));
    s.rs2       = 5'($urandom_range(0, 3));
    s.use1      = $urandom_range(0, 1);
    s.use2      = $urandom_range(0, 1);
    s.ex_pc     = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
    s.target    = $urandom() & 32'hFFFF_FFFC;
    case ($urandom_range(0, 2))
      0:       s.id_pc = s.target;
      1:       s.id_pc = s.ex_pc + 32'd4;
      default: s.id_pc = $urandom() & 32'hFFFF_FFFC;
    endcase
    return s;
  endfunction

  // Monitor: outputs are valid every cycle; compare mid-cycle at negedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stall_fetch",    32'(stall_fetch),    32'(e.stall));
      check("id_bubble",      32'(id_bubble),      32'(e.bubble));
      check("flush_if",       32'(flush_if),       32'(e.flush));
      check("redirect_valid", 32'(redirect_valid), 32'(e.rv));
      check("redirect_pc",    redirect_pc,         e.rpc);
      check("busy",           32'(busy),           32'(e.busy));
      check("mispredict_cnt", 32'(mispredict_cnt), 32'(e.mcnt));
      check("loaduse_cnt",    32'(loaduse_cnt),    32'(e.lcnt));
    end
  end

  initial begin
    stim_t s;
    n_checks = 0; n_errors = 0; mis_n = 0; lu_n = 0;

    repeat (3) step(idle(), 1'b1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_stall", 32'(stall_fetch), 32'd0);

    // jal redirect then two flush bubbles
    step(jal_at(32'h100, 32'h80), 1'b0);
    check("jal_redirect_pc", redirect_pc, 32'h100);
    check("jal_flush_if", 32'(flush_if), 32'd1);
    step(idle(), 1'b0);
    check("flush1_bubble", 32'(id_bubble), 32'd1);
    check("flush1_no_flush_if", 32'(flush_if), 32'd0);
    step(idle(), 1'b0);
    check("flush2_bubble", 32'(id_bubble), 32'd1);
    step(idle(), 1'b0);
    check("flush_done_bubble", 32'(id_bubble), 32'd0);
    check("jal_mcnt", 32'(mispredict_cnt), 32'd1);

    // bne not taken: correct and wrong fall-through
    s = idle();
    s.ex_valid = 1; s.op = OP_BR; s.br_en = 0; s.ex_pc = 32'h40; s.id_valid = 1; s.id_pc = 32'h44;
    step(s, 1'b0);
    check("bne_ok_no_redirect", 32'(redirect_valid), 32'd0);
    check("bne_ok_no_bubble", 32'(id_bubble), 32'd0);
    s.id_pc = 32'h90;
    step(s, 1'b0);
    check("bne_bad_redirect_pc", redirect_pc, 32'h44);
    repeat (2) step(idle(), 1'b0);

    // load-use: two stall cycles
    step(lw_at(5'd5, 5'd5, 1'b1), 1'b0);
    check("lu_stall", 32'(stall_fetch), 32'd1);
    step(idle(), 1'b0);
    check("lu_stall2", 32'(stall_fetch), 32'd1);
    step(idle(), 1'b0);
    check("lu_done", 32'(stall_fetch), 32'd0);
    check("lu_cnt", 32'(loaduse_cnt), 32'd1);

    // x0 destination and non-reading consumer never stall
    step(lw_at(5'd0, 5'd0, 1'b1), 1'b0);
    check("lw_x0_no_stall", 32'(stall_fetch), 32'd0);
    step(lw_at(5'd5, 5'd5, 1'b0), 1'b0);
    check("lui_no_stall", 32'(stall_fetch), 32'd0);

    // mispredict arriving inside a load-use stall wins
    step(lw_at(5'd7, 5'd7, 1'b1), 1'b0);
    step(jal_at(32'h200, 32'h10), 1'b0);
    check("mis_over_stall_rv", 32'(redirect_valid), 32'd1);
    check("mis_over_stall_stall", 32'(stall_fetch), 32'd0);

    // cache miss during flush freezes the sequence
    s = idle();
    s.mem_ready = 0;
    repeat (3) begin
      step(s, 1'b0);
      check("miss_stall", 32'(stall_fetch), 32'd1);
    end
    repeat (3) step(idle(), 1'b0);

    // async reset mid load-use stall
    step(lw_at(5'd3, 5'd3, 1'b1), 1'b0);
    step(idle(), 1'b1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_cnt", 32'(loaduse_cnt), 32'd0);
    step(idle(), 1'b0);

    // saturation
    repeat (20) step(jal_at(32'h300, 32'h0), 1'b0);
    step(idle(), 1'b0);
    check("mcnt_saturated", 32'(mispredict_cnt), 32'(CNT_MAX));

    repeat (2000) step(rand_stim(), ($urandom_range(0, 199) == 0));

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
